// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: default register-file geometry, register
// index / data word types and the hardwired-zero register index.
// No ports.

package cpu_pkg;

   localparam int REG_W  = 5;    // register address width
   localparam int REG_S  = 32;   // number of architectural registers
   localparam int DATA_W = 32;   // operand width

   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode -> operand fetch -> execute handshake bundle.
//   in_*  : decoded instruction channel (valid/ready, rs1, rs2, rd, rd_we)
//   out_* : operand channel toward execute (valid/ready, op1, op2, rd, rd_we)
// master : environment view (drives instructions, accepts operands)
// slave  : operand_fetch view

interface operand_fetch_if #(
   parameter int REG_W  = cpu_pkg::REG_W,
   parameter int DATA_W = cpu_pkg::DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [REG_W-1:0]  in_rs1;
   logic [REG_W-1:0]  in_rs2;
   logic [REG_W-1:0]  in_rd;
   logic              in_rd_we;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [REG_W-1:0]  out_rd;
   logic              out_rd_we;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-writeback tracker.
//   clk, rst_n       : clock, async active-low reset (clears all busy bits)
//   set_en/set_idx   : mark a register as having an in-flight writer
//   clr_en/clr_idx   : writeback retired for a register
//   q1/q2_idx, busy  : source operand queries (combinational)
//   qw_idx, busy     : destination (WAW) query (combinational)
// Set and clear of the same register in one cycle leaves it busy.

module reg_scoreboard #(
   parameter int REG_W = cpu_pkg::REG_W,
   parameter int REG_S = cpu_pkg::REG_S
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_idx,
   input  logic [REG_W-1:0] q1_idx,
   output logic             q1_busy,
   input  logic [REG_W-1:0] q2_idx,
   output logic             q2_busy,
   input  logic [REG_W-1:0] qw_idx,
   output logic             qw_busy
);
   import cpu_pkg::*;

   logic [REG_S-1:0] busy;

   // Clear first, set last, so a same-cycle set on the same index wins.
   // x0 never gets a pending writer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (clr_en)
            busy[clr_idx] <= 1'b0;
         if (set_en && set_idx != REG_ZERO)
            busy[set_idx] <= 1'b1;
      end
   end

   assign q1_busy = busy[q1_idx];
   assign q2_busy = busy[q2_idx];
   assign qw_busy = busy[qw_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 from the register file, stalls on
// RAW/WAW hazards against pending writebacks, and holds one operand entry
// for execute.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : drop the held entry (branch redirect)
//   bus (slave)           : decode-in / execute-out handshake bundle
//   rf_a1/rf_a2           : rfile read addresses (= in_rs1/in_rs2)
//   rf_rd1/rf_rd2         : rfile asynchronous read data
//   wb_valid/wb_rd/wb_data: writeback bus (also writes the rfile)
// Build option: OPERAND_FETCH_WB_BYPASS_EN forwards same-cycle writeback
// data into captured operands and lets a register being cleared this cycle
// through without a stall. Without it, a dependent instruction waits until
// the cycle after the writeback, when the rfile holds the new value.

module operand_fetch #(
   parameter int REG_W  = cpu_pkg::REG_W,
   parameter int REG_S  = cpu_pkg::REG_S,
   parameter int DATA_W = cpu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   operand_fetch_if.slave    bus,
   output logic [REG_W-1:0]  rf_a1,
   output logic [REG_W-1:0]  rf_a2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   input  logic              wb_valid,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data
);
   import cpu_pkg::*;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [REG_W-1:0]  rd;
      logic              rd_we;
   } entry_t;

   entry_t            ent_q;
   logic              busy1, busy2, busyw;
   logic              clr1, clr2, clrw;
   logic              fwd1, fwd2;
   logic              hz_raw, hz_waw, hz_hold, hazard;
   logic              in_fire, out_fire;
   logic [DATA_W-1:0] op1, op2;

   assign rf_a1 = bus.in_rs1;
   assign rf_a2 = bus.in_rs2;

   // A writeback this cycle to a queried register: bypass build uses it to
   // both release the stall and supply the data.
`ifdef OPERAND_FETCH_WB_BYPASS_EN
   assign fwd1 = wb_valid && wb_rd == bus.in_rs1;
   assign fwd2 = wb_valid && wb_rd == bus.in_rs2;
   assign clr1 = fwd1;
   assign clr2 = fwd2;
   assign clrw = wb_valid && wb_rd == bus.in_rd;
`else
   logic unused_wb;
   assign fwd1      = 1'b0;
   assign fwd2      = 1'b0;
   assign clr1      = 1'b0;
   assign clr2      = 1'b0;
   assign clrw      = 1'b0;
   assign unused_wb = ^wb_data;
`endif

   reg_scoreboard #(.REG_W(REG_W), .REG_S(REG_S)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (out_fire && ent_q.rd_we && ent_q.rd != REG_ZERO),
      .set_idx (ent_q.rd),
      .clr_en  (wb_valid),
      .clr_idx (wb_rd),
      .q1_idx  (bus.in_rs1),
      .q1_busy (busy1),
      .q2_idx  (bus.in_rs2),
      .q2_busy (busy2),
      .qw_idx  (bus.in_rd),
      .qw_busy (busyw)
   );

   assign hz_raw = (bus.in_rs1 != REG_ZERO && busy1 && !clr1) ||
                   (bus.in_rs2 != REG_ZERO && busy2 && !clr2);
   assign hz_waw = bus.in_rd_we && bus.in_rd != REG_ZERO && busyw && !clrw;

   // The held entry only enters the scoreboard when it fires, so compare
   // against it directly.
   assign hz_hold = ent_q.valid && ent_q.rd_we && ent_q.rd != REG_ZERO &&
                    (ent_q.rd == bus.in_rs1 || ent_q.rd == bus.in_rs2 ||
                     (bus.in_rd_we && ent_q.rd == bus.in_rd));

   assign hazard       = hz_raw || hz_waw || hz_hold;
   assign out_fire     = ent_q.valid && bus.out_ready;
   assign bus.in_ready = !flush && (!ent_q.valid || bus.out_ready) && !hazard;
   assign in_fire      = bus.in_valid && bus.in_ready;

   always_comb begin
      op1 = rf_rd1;
      op2 = rf_rd2;
      if (fwd1) op1 = wb_data;
      if (fwd2) op2 = wb_data;
      if (bus.in_rs1 == REG_ZERO) op1 = '0;
      if (bus.in_rs2 == REG_ZERO) op2 = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
      end else if (flush) begin
         ent_q.valid <= 1'b0;
      end else if (in_fire) begin
         ent_q <= '{valid: 1'b1, op1: op1, op2: op2,
                    rd: bus.in_rd, rd_we: bus.in_rd_we};
      end else if (out_fire) begin
         ent_q.valid <= 1'b0;
      end
   end

   assign bus.out_valid = ent_q.valid;
   assign bus.out_op1   = ent_q.op1;
   assign bus.out_op2   = ent_q.op2;
   assign bus.out_rd    = ent_q.rd;
   assign bus.out_rd_we = ent_q.rd_we;

endmodule
